// File: rtl/hashmap_pin_pkg.sv
// Shared types and sizing helpers for the pin-limited hashmap host driver.
package hashmap_pin_pkg;
    localparam int KEY_BITS_DEF = 64;
    localparam int VAL_BITS_DEF = 64;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_LOOKUP = 2'd1,
        OP_MODIFY = 2'd2,
        OP_DELETE = 2'd3
    } hm_op_t;

    function automatic int shift_len(input int key_bits, input int val_bits);
        return (key_bits > val_bits) ? key_bits : val_bits;
    endfunction
endpackage

// File: rtl/hashmap_pin_rx.sv
// Deserialiser for the returned value stream: valid_p marks the MSB, value_p carries
// VAL_BITS bits MSB first; a fresh valid_p mid-word restarts capture and flags overrun.
module hashmap_pin_rx
    import hashmap_pin_pkg::*;
#(
    parameter int VAL_BITS = VAL_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_p,
    input  logic                value_p,
    output logic                rsp_valid,
    output logic [VAL_BITS-1:0] rsp_value,
    output logic                rsp_overrun
);
    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

    localparam int CW = $clog2(VAL_BITS + 1);
    localparam int SW = VAL_BITS - 1;

    rx_state_t     r_state, w_nxt_state;
    logic [CW-1:0] r_cnt, w_nxt_cnt;
    // Holds the bits already received; the final bit is taken straight from the pin.
    logic [SW-1:0] r_sh, w_nxt_sh;
    logic          w_done;
    logic          w_overrun;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_sh    = r_sh;
        w_done      = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (valid_p) begin
                    w_nxt_state = RX_SHIFT;
                    w_nxt_cnt   = CW'(1);
                    w_nxt_sh    = SW'(value_p);
                end
            end
            RX_SHIFT: begin
                if (valid_p) begin
                    w_overrun = 1'b1;
                    w_nxt_cnt = CW'(1);
                    w_nxt_sh  = SW'(value_p);
                end else if (r_cnt == CW'(VAL_BITS - 1)) begin
                    w_done      = 1'b1;
                    w_nxt_state = RX_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                    w_nxt_sh  = {r_sh[SW-2:0], value_p};
                end
            end
            default: w_nxt_state = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RX_IDLE;
            r_cnt       <= '0;
            r_sh        <= '0;
            rsp_valid   <= 1'b0;
            rsp_value   <= '0;
            rsp_overrun <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_sh        <= w_nxt_sh;
            rsp_valid   <= w_done;
            rsp_overrun <= w_overrun;
            if (w_done) begin
                rsp_value <= {r_sh, value_p};
            end
        end
    end
endmodule

// File: rtl/hashmap_pin_driver.sv
// Host-side driver for the pin-limited serial hashmap: serialises parallel commands
// onto the 1-bit pins and hands the returned value stream to the deserialiser.
//
//   state     | meaning
//   IDLE      | ready for a command
//   WAIT_BUSY | insert accepted, waiting for busy_p to drop
//   SHIFT     | shifting SHIFT_LEN bits, strobes on the last bit
//   GUARD     | post-insert hold-off while busy_p propagates back
module hashmap_pin_driver
    import hashmap_pin_pkg::*;
#(
    parameter int KEY_BITS   = KEY_BITS_DEF,
    parameter int VAL_BITS   = VAL_BITS_DEF,
    parameter int BUSY_GUARD = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [KEY_BITS-1:0] cmd_key,
    input  logic [VAL_BITS-1:0] cmd_value,
    output logic                insert_p,
    output logic                ins_key_p,
    output logic                ins_value_p,
    output logic                lookup_p,
    output logic                key_p,
    output logic                modify_p,
    output logic                del_p,
    output logic                mod_value_p,
    input  logic                busy_p,
    input  logic                valid_p,
    input  logic                value_p,
    output logic                rsp_valid,
    output logic [VAL_BITS-1:0] rsp_value,
    output logic                rsp_overrun
);
    localparam int SL = shift_len(KEY_BITS, VAL_BITS);
    localparam int CW = $clog2(SL + BUSY_GUARD + 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, SHIFT, GUARD} tx_state_t;

    tx_state_t     r_state, w_nxt_state;
    hm_op_t        r_op, w_nxt_op;
    logic [CW-1:0] r_cnt, w_nxt_cnt;
    logic [SL-1:0] r_sh_key, w_nxt_sh_key;
    logic [SL-1:0] r_sh_val, w_nxt_sh_val;
    logic          w_shift_nxt;
    logic          w_last_nxt;
    logic          w_ins_nxt;

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_op     = r_op;
        w_nxt_cnt    = r_cnt;
        w_nxt_sh_key = r_sh_key;
        w_nxt_sh_val = r_sh_val;
        case (r_state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_nxt_op     = hm_op_t'(cmd_op);
                    w_nxt_cnt    = '0;
                    w_nxt_sh_key = SL'(cmd_key);
                    w_nxt_sh_val = SL'(cmd_value);
                    w_nxt_state  = (hm_op_t'(cmd_op) == OP_INSERT) ? WAIT_BUSY : SHIFT;
                end
            end
            WAIT_BUSY: begin
                if (!busy_p) begin
                    w_nxt_state = SHIFT;
                end
            end
            SHIFT: begin
                w_nxt_sh_key = {r_sh_key[SL-2:0], 1'b0};
                w_nxt_sh_val = {r_sh_val[SL-2:0], 1'b0};
                if (r_cnt == CW'(SL - 1)) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = (r_op == OP_INSERT && BUSY_GUARD > 0) ? GUARD : IDLE;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            GUARD: begin
                if (r_cnt == CW'(BUSY_GUARD - 1)) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = IDLE;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // Pins are registered from next-state values so each cycle's pin levels match its state.
    assign w_shift_nxt = (w_nxt_state == SHIFT);
    assign w_last_nxt  = w_shift_nxt && (w_nxt_cnt == CW'(SL - 1));
    assign w_ins_nxt   = (w_nxt_op == OP_INSERT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= OP_INSERT;
            r_cnt       <= '0;
            r_sh_key    <= '0;
            r_sh_val    <= '0;
            cmd_ready   <= 1'b0;
            insert_p    <= 1'b0;
            ins_key_p   <= 1'b0;
            ins_value_p <= 1'b0;
            lookup_p    <= 1'b0;
            key_p       <= 1'b0;
            modify_p    <= 1'b0;
            del_p       <= 1'b0;
            mod_value_p <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_op        <= w_nxt_op;
            r_cnt       <= w_nxt_cnt;
            r_sh_key    <= w_nxt_sh_key;
            r_sh_val    <= w_nxt_sh_val;
            cmd_ready   <= (w_nxt_state == IDLE);
            ins_key_p   <= w_shift_nxt && w_ins_nxt && w_nxt_sh_key[SL-1];
            ins_value_p <= w_shift_nxt && w_ins_nxt && w_nxt_sh_val[SL-1];
            key_p       <= w_shift_nxt && !w_ins_nxt && w_nxt_sh_key[SL-1];
            mod_value_p <= w_shift_nxt && (w_nxt_op == OP_MODIFY) && w_nxt_sh_val[SL-1];
            insert_p    <= w_last_nxt && w_ins_nxt;
            lookup_p    <= w_last_nxt && !w_ins_nxt;
            modify_p    <= w_last_nxt && (w_nxt_op == OP_MODIFY);
            del_p       <= w_last_nxt && (w_nxt_op == OP_DELETE);
        end
    end

    hashmap_pin_rx #(
        .VAL_BITS(VAL_BITS)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .valid_p    (valid_p),
        .value_p    (value_p),
        .rsp_valid  (rsp_valid),
        .rsp_value  (rsp_value),
        .rsp_overrun(rsp_overrun)
    );
endmodule

// File: tb/tb_hashmap_pin_driver.sv
// Self-checking bench for hashmap_pin_driver: directed command table, random commands
// against a pin-level model, and directed/random response-stream sequences.
module tb_hashmap_pin_driver;
    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_key;
    logic [63:0] cmd_value;
    logic        insert_p, ins_key_p, ins_value_p, lookup_p, key_p;
    logic        modify_p, del_p, mod_value_p;
    logic        busy_p, valid_p, value_p;
    logic        rsp_valid, rsp_overrun;
    logic [63:0] rsp_value;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ovr_n = 0;
    logic [63:0] q_val[$];
    int          q_t[$];

    hashmap_pin_driver dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_value(cmd_value),
        .insert_p(insert_p), .ins_key_p(ins_key_p), .ins_value_p(ins_value_p),
        .lookup_p(lookup_p), .key_p(key_p), .modify_p(modify_p), .del_p(del_p),
        .mod_value_p(mod_value_p), .busy_p(busy_p), .valid_p(valid_p), .value_p(value_p),
        .rsp_valid(rsp_valid), .rsp_value(rsp_value), .rsp_overrun(rsp_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rsp_valid) begin
            q_val.push_back(rsp_value);
            q_t.push_back(cyc);
        end
        if (rsp_overrun) ovr_n++;
    end

    logic [10:0] w_outs;
    assign w_outs = {cmd_ready, insert_p, ins_key_p, ins_value_p, lookup_p, key_p,
                     modify_p, del_p, mod_value_p, rsp_valid, rsp_overrun};

    typedef struct {
        logic [1:0]  op;
        logic [63:0] key;
        logic [63:0] val;
        int          busy;
        bit          gbusy;
        logic [63:0] e_key;
        logic [63:0] e_ik;
        logic [63:0] e_iv;
        logic [63:0] e_mv;
        logic [3:0]  e_strb;   // {insert_p, lookup_p, modify_p, del_p} on the final bit
        int          e_ready;  // cycles after acceptance until cmd_ready is seen again
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pin-level expectations from the command rules: which pin carries which field,
    // which strobes fire, and how long the command occupies the driver.
    function automatic vec_t model(input logic [1:0] op, input logic [63:0] k,
                                   input logic [63:0] v, input int b);
        vec_t r;
        r.op = op; r.key = k; r.val = v; r.busy = b; r.gbusy = 1'b0;
        r.e_key = (op != 2'd0) ? k : 64'd0;
        r.e_ik  = (op == 2'd0) ? k : 64'd0;
        r.e_iv  = (op == 2'd0) ? v : 64'd0;
        r.e_mv  = (op == 2'd2) ? v : 64'd0;
        case (op)
            2'd0:    r.e_strb = 4'b1000;
            2'd1:    r.e_strb = 4'b0100;
            2'd2:    r.e_strb = 4'b0110;
            default: r.e_strb = 4'b0101;
        endcase
        // insert: busy wait + 1 wait cycle + 64 shift + 4 guard
        r.e_ready = (op == 2'd0) ? b + 69 : 64;
        return r;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [63:0] wk, wik, wiv, wmv;
        logic [3:0]  strb;
        int stray, first, last, rdy, guard;
        bit ins;
        ins   = (v.op == 2'd0);
        first = ins ? v.busy + 1 : 0;
        last  = first + 63;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            tick();
            guard++;
        end
        cmd_valid = 1'b1; cmd_op = v.op; cmd_key = v.key; cmd_value = v.val;
        busy_p = (v.busy > 0);
        tick();
        cmd_valid = 1'b0; cmd_key = ~v.key; cmd_value = ~v.val; cmd_op = ~v.op;
        wk = '0; wik = '0; wiv = '0; wmv = '0; strb = '0; stray = 0; rdy = -1;
        for (int k = 0; k < 300 && rdy < 0; k++) begin
            if (k >= first && k <= last) begin
                wk  = {wk[62:0], key_p};
                wik = {wik[62:0], ins_key_p};
                wiv = {wiv[62:0], ins_value_p};
                wmv = {wmv[62:0], mod_value_p};
            end else begin
                stray += int'(key_p) + int'(ins_key_p) + int'(ins_value_p) + int'(mod_value_p);
            end
            if (k == last) strb = {insert_p, lookup_p, modify_p, del_p};
            else stray += int'(insert_p) + int'(lookup_p) + int'(modify_p) + int'(del_p);
            if (cmd_ready) begin
                rdy = k;
            end else begin
                busy_p = (k < v.busy) || (v.gbusy && ins && k >= last);
                tick();
            end
        end
        busy_p = 1'b0;
        chk("key_p word", wk, v.e_key);
        chk("ins_key_p word", wik, v.e_ik);
        chk("ins_value_p word", wiv, v.e_iv);
        chk("mod_value_p word", wmv, v.e_mv);
        chk("strobes on last bit", 64'(strb), 64'(v.e_strb));
        chk("stray pin activity", 64'(stray), 64'd0);
        chk("cmd_ready return cycle", 64'(rdy), 64'(v.e_ready));
    endtask

    task automatic rx_word(input logic [63:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            valid_p = (i == 0);
            value_p = w[63-i];
            tick();
        end
        valid_p = 1'b0;
        value_p = 1'b0;
    endtask

    task automatic rx_random(input int n);
        logic [63:0] w;
        logic [63:0] exp_val[$];
        int exp_t[$];
        int exp_ovr, ovr0, nmin;
        exp_ovr = 0;
        ovr0 = ovr_n;
        q_val.delete(); q_t.delete();
        for (int i = 0; i < n; i++) begin
            w = {$urandom, $urandom};
            if ($urandom_range(2) == 0) begin
                rx_word({$urandom, $urandom}, $urandom_range(62, 1));
                exp_ovr++;
            end else begin
                repeat ($urandom_range(3)) tick();
            end
            exp_val.push_back(w);
            exp_t.push_back(cyc + 1);
            rx_word(w, 64);
        end
        repeat (3) tick();
        chk("rx random count", 64'(q_val.size()), 64'(exp_val.size()));
        chk("rx random overruns", 64'(ovr_n - ovr0), 64'(exp_ovr));
        nmin = (q_val.size() < exp_val.size()) ? q_val.size() : exp_val.size();
        for (int i = 0; i < nmin; i++) begin
            chk("rx random value", q_val[i], exp_val[i]);
            chk("rx random latency", 64'(q_t[i] - exp_t[i]), 64'd63);
        end
    endtask

    vec_t vecs[5];
    logic [63:0] k_rst;
    int t0, t1, ovr0;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0; cmd_value = '0;
        busy_p = 1'b0; valid_p = 1'b0; value_p = 1'b0;
        #2 rst = 1'b1;
        tick(); tick();
        chk("reset outputs", 64'(w_outs), 64'd0);
        chk("reset rsp_value", rsp_value, 64'd0);
        rst = 1'b0;
        tick();
        chk("cmd_ready after reset", 64'(cmd_ready), 64'd1);

        vecs[0] = '{2'd1, 64'h0123_4567_89AB_CDEF, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1'b0,
                    64'h0123_4567_89AB_CDEF, 64'd0, 64'd0, 64'd0, 4'b0100, 64};
        vecs[1] = '{2'd0, 64'h1, 64'hFFFF_0000_0000_0001, 10, 1'b1,
                    64'd0, 64'h1, 64'hFFFF_0000_0000_0001, 64'd0, 4'b1000, 79};
        vecs[2] = '{2'd2, 64'h5A5A_5A5A_C3C3_C3C3, 64'h1234_5678_9ABC_DEF0, 0, 1'b0,
                    64'h5A5A_5A5A_C3C3_C3C3, 64'd0, 64'd0, 64'h1234_5678_9ABC_DEF0, 4'b0110, 64};
        vecs[3] = '{2'd3, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0,
                    64'h8000_0000_0000_0001, 64'd0, 64'd0, 64'd0, 4'b0101, 64};
        vecs[4] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 1'b0,
                    64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 4'b1000, 69};
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // reset in the middle of a lookup shift
        k_rst = 64'hC0FF_EE00_1234_5678;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_key = k_rst; cmd_value = '0;
        tick();
        cmd_valid = 1'b0;
        repeat (30) tick();
        chk("key_p at shift 30", 64'(key_p), 64'(k_rst[33]));
        #2 rst = 1'b1;
        #1;
        chk("async reset outputs", 64'(w_outs), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("cmd_ready after mid-shift reset", 64'(cmd_ready), 64'd1);
        run_vec(model(2'd1, 64'h9E37_79B9_7F4A_7C15, 64'd0, 0));

        // response: single word
        q_val.delete(); q_t.delete(); ovr0 = ovr_n;
        t0 = cyc + 1;
        rx_word(64'hDEAD_BEEF_0000_0001, 64);
        repeat (3) tick();
        chk("rx single count", 64'(q_val.size()), 64'd1);
        if (q_val.size() > 0) begin
            chk("rx single value", q_val[0], 64'hDEAD_BEEF_0000_0001);
            chk("rx single latency", 64'(q_t[0] - t0), 64'd63);
        end
        chk("rx single overrun", 64'(ovr_n - ovr0), 64'd0);

        // response: restart 20 bits into a capture
        q_val.delete(); q_t.delete(); ovr0 = ovr_n;
        rx_word(64'h1111_2222_3333_4444, 20);
        t1 = cyc + 1;
        rx_word(64'h0F0E_0D0C_0B0A_0908, 64);
        repeat (3) tick();
        chk("rx overrun pulses", 64'(ovr_n - ovr0), 64'd1);
        chk("rx overrun count", 64'(q_val.size()), 64'd1);
        if (q_val.size() > 0) begin
            chk("rx overrun value", q_val[0], 64'h0F0E_0D0C_0B0A_0908);
            chk("rx overrun latency", 64'(q_t[0] - t1), 64'd63);
        end

        // random commands and random response traffic concurrently
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    run_vec(model(2'($urandom_range(3)), {$urandom, $urandom},
                                  {$urandom, $urandom}, $urandom_range(5)));
                end
            end
            rx_random(8);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
